char_plotter: RTL and testbench
===============================

Name: char_plotter

Overview:
- Sequential glyph rasteriser that drives a combinational character LUT decoder and turns its answers into pixel writes for the VGA frame-buffer writer.
- On start it latches a character origin and sweeps absolute flush coordinates across a CHAR_W x CHAR_H box, one pixel per clock.
- Each lit pixel is emitted as a valid/ready plot transaction; completion is signalled with a done pulse.
- Sits between the game's sprite/text sequencer and the VGA adapter, alongside the char decoders.

Parameters:
- CHAR_W, 8, glyph box width in pixels, 1..255.
- CHAR_H, 10, glyph box height in pixels, 1..255.
- BG_COLOUR, 6'b000000, colour written for unlit pixels; used only with CLEAR_BG_EN.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  begin plotting one character; sampled only in IDLE
- origin_x  input  8  character box left x, latched on start
- origin_y  input  8  character box top y, latched on start
- char_x  output  8  latched origin x, to decoder x input
- char_y  output  8  latched origin y, to decoder y input
- flush_x  output  8  absolute query x = char_x + dx (mod 256), to decoder
- flush_y  output  8  absolute query y = char_y + dy (mod 256), to decoder
- glyph_en  input  1  decoder enable for the current flush point (combinational, same cycle)
- glyph_colour  input  6  decoder colour for the current flush point
- plot  output  1  plot valid
- plot_ready  input  1  writer accepts; transfer when plot && plot_ready
- plot_x  output  8  pixel x
- plot_y  output  8  pixel y
- plot_colour  output  6  pixel colour
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous: state = IDLE. dx, dy, char_x, char_y, plot_x, plot_y, plot_colour = 0. plot, busy, done = 0.
- States: IDLE, SCAN, DRAIN, FIN.
- IDLE: on start = 1, latch origin, clear dx and dy, go to SCAN. Start is ignored in every other state.
- SCAN, per cycle:
  - The output register is free when plot = 0 or (plot && plot_ready).
  - If free: sample glyph_en/glyph_colour for the current (dx, dy).
    - If lit: load plot = 1, plot_x = flush_x, plot_y = flush_y, plot_colour = glyph_colour.
    - If unlit: plot <= 0 when the old value transferred.
    - Then advance. dx++; when dx == CHAR_W-1, wrap dx to 0 and dy++.
  - If not free: stall. dx, dy and the plot register hold, and flush_x/flush_y stay stable.
  - On advancing from (CHAR_W-1, CHAR_H-1), go to DRAIN.
- DRAIN: wait until plot == 0 or a transfer occurs, then clear plot and go to FIN.
- FIN: done = 1 for exactly one cycle, busy = 0, return to IDLE.
- Plot handshake:
  - plot_x, plot_y and plot_colour are stable while plot && !plot_ready.
  - No pixel is dropped or duplicated.
- Coordinate arithmetic: 8-bit wraparound. Origin 250 with dx 7 gives flush_x 1. No clipping.
- Latency: with plot_ready held at 1, done is high in the 82nd cycle after the start edge for the 8x10 default. That is 80 scan cycles + 1 drain + 1 fin, independent of glyph content.
- Reset mid-operation: abort immediately. No further plot, no done pulse.

Optional Feature:
- Macro: CLEAR_BG_EN.
- Defined: unlit pixels also produce a plot with plot_colour = BG_COLOUR. Every box pixel is written exactly once, in row-major order.
- Undefined: only pixels with glyph_en = 1 are plotted. BG_COLOUR is unused.

Test Plan:
- Decoder for glyph F, origin (20,30), plot_ready = 1 -> exactly 16 plots, row-major. First plot is (23,30); the col-3 pixels are (23,31..39); the row-5 pixels are (24..26,35). done pulses once, 82 cycles after start.
- Same glyph, plot_ready toggling 1,0,0,1... -> identical 16-plot sequence, coordinates held while stalled, done only after the final transfer.
- Origin (252,250) -> flush coordinates wrap. Plots include (255,250), (0,250), (2,250) and rows wrapping y 255 to 3.
- start pulsed again while busy with a different origin -> ignored, first character completes unchanged. A second start after done renders at the new origin.
- resetn asserted at scan pixel 40 -> plot, busy, done fall to 0 asynchronously. No done pulse. The next start renders the full glyph correctly.
- CLEAR_BG_EN defined, BG_COLOUR = 6'b000011 -> 80 plots, 16 with colour 6'b111111 and 64 with 6'b000011.

Source files
------------

// File: rtl/char_plotter.sv
// Glyph rasteriser: sweeps a CHAR_W x CHAR_H box, queries the char decoder and
// emits lit pixels as valid/ready plot writes. Optional macro: CLEAR_BG_EN.
module char_plotter #(
    parameter int           CHAR_W    = 8,
    parameter int           CHAR_H    = 10,
    parameter logic [5:0]   BG_COLOUR = 6'b000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  origin_x,
    input  logic [7:0]  origin_y,
    output logic [7:0]  char_x,
    output logic [7:0]  char_y,
    output logic [7:0]  flush_x,
    output logic [7:0]  flush_y,
    input  logic        glyph_en,
    input  logic [5:0]  glyph_colour,
    output logic        plot,
    input  logic        plot_ready,
    output logic [7:0]  plot_x,
    output logic [7:0]  plot_y,
    output logic [5:0]  plot_colour,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [7:0] LAST_X = 8'(CHAR_W - 1);
    localparam logic [7:0] LAST_Y = 8'(CHAR_H - 1);

    state_t      state_r;
    logic [7:0]  dx_r;
    logic [7:0]  dy_r;
    logic [7:0]  char_x_r;
    logic [7:0]  char_y_r;
    logic        plot_r;
    logic [7:0]  plot_x_r;
    logic [7:0]  plot_y_r;
    logic [5:0]  plot_colour_r;
    logic        busy_r;
    logic        done_r;

    logic        free_s;
    logic        pix_on_s;
    logic [5:0]  colour_s;
    logic [7:0]  flush_x_s;
    logic [7:0]  flush_y_s;

    assign flush_x_s   = char_x_r + dx_r;
    assign flush_y_s   = char_y_r + dy_r;
    // Output slot can take a new pixel when empty or being consumed this cycle.
    assign free_s      = !plot_r || plot_ready;

    assign char_x      = char_x_r;
    assign char_y      = char_y_r;
    assign flush_x     = flush_x_s;
    assign flush_y     = flush_y_s;
    assign plot        = plot_r;
    assign plot_x      = plot_x_r;
    assign plot_y      = plot_y_r;
    assign plot_colour = plot_colour_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Decide whether the current box pixel produces a write and with which colour.
    always_comb begin
`ifdef CLEAR_BG_EN
        pix_on_s = 1'b1;
`else
        pix_on_s = glyph_en;
`endif
        if (glyph_en) begin
            colour_s = glyph_colour;
        end else begin
            colour_s = BG_COLOUR;
        end
    end

    // Control FSM with the plot output register and scan counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= IDLE;
            dx_r          <= 8'd0;
            dy_r          <= 8'd0;
            char_x_r      <= 8'd0;
            char_y_r      <= 8'd0;
            plot_r        <= 1'b0;
            plot_x_r      <= 8'd0;
            plot_y_r      <= 8'd0;
            plot_colour_r <= 6'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        char_x_r <= origin_x;
                        char_y_r <= origin_y;
                        dx_r     <= 8'd0;
                        dy_r     <= 8'd0;
                        busy_r   <= 1'b1;
                        state_r  <= SCAN;
                    end
                end
                SCAN: begin
                    if (free_s) begin
                        if (pix_on_s) begin
                            plot_r        <= 1'b1;
                            plot_x_r      <= flush_x_s;
                            plot_y_r      <= flush_y_s;
                            plot_colour_r <= colour_s;
                        end else begin
                            plot_r <= 1'b0;
                        end
                        if (dx_r == LAST_X) begin
                            dx_r <= 8'd0;
                            dy_r <= dy_r + 8'd1;
                            if (dy_r == LAST_Y) begin
                                state_r <= DRAIN;
                            end
                        end else begin
                            dx_r <= dx_r + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (free_s) begin
                        plot_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= FIN;
                    end
                end
                FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    plot_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_plotter.sv
// Self-checking bench for char_plotter: glyph-F decoder, pixel-queue model,
// per-cycle compare process and hand-computed literal expectations.
module tb_char_plotter;

    localparam int         W  = 8;
    localparam int         H  = 10;
    localparam logic [5:0] BG = 6'b000011;
    localparam logic [5:0] FG = 6'b111111;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  origin_x;
    logic [7:0]  origin_y;
    logic [7:0]  char_x;
    logic [7:0]  char_y;
    logic [7:0]  flush_x;
    logic [7:0]  flush_y;
    logic        glyph_en;
    logic [5:0]  glyph_colour;
    logic        plot;
    logic        plot_ready;
    logic [7:0]  plot_x;
    logic [7:0]  plot_y;
    logic [5:0]  plot_colour;
    logic        busy;
    logic        done;

    char_plotter #(.CHAR_W(W), .CHAR_H(H), .BG_COLOUR(BG)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .origin_x(origin_x), .origin_y(origin_y),
        .char_x(char_x), .char_y(char_y),
        .flush_x(flush_x), .flush_y(flush_y),
        .glyph_en(glyph_en), .glyph_colour(glyph_colour),
        .plot(plot), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [5:0] c;
    } pix_t;

    int   checks   = 0;
    int   failures = 0;
    pix_t exp_q[$];
    pix_t got_log[$];
    bit   active   = 1'b0;
    int   cyc      = 0;
    int   done_cyc = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    int   ready_ph   = 0;
    bit   prev_stall = 1'b0;
    pix_t prev_pix;

    // Glyph F: column 3 full height, rows 0 and 5 extended over columns 4..6.
    function automatic bit glyph_f(input logic [7:0] rx, input logic [7:0] ry);
        return (rx == 8'd3 && ry < 8'd10) ||
               ((ry == 8'd0 || ry == 8'd5) && rx >= 8'd4 && rx <= 8'd6);
    endfunction

    always_comb begin
        glyph_en     = glyph_f(8'(flush_x - char_x), 8'(flush_y - char_y));
        glyph_colour = FG;
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void build_expect(input logic [7:0] ox, input logic [7:0] oy);
        pix_t p;
        exp_q.delete();
        got_log.delete();
        for (int dy = 0; dy < H; dy++) begin
            for (int dx = 0; dx < W; dx++) begin
                p.x = 8'(int'(ox) + dx);
                p.y = 8'(int'(oy) + dy);
                if (glyph_f(8'(dx), 8'(dy))) begin
                    p.c = FG;
                    exp_q.push_back(p);
                end else begin
`ifdef CLEAR_BG_EN
                    p.c = BG;
                    exp_q.push_back(p);
`endif
                end
            end
        end
    endfunction

    // Compare process: every falling edge, check the DUT against the pixel queue.
    always @(negedge clk) begin
        bit was_active;
        pix_t e;
        if (!resetn) begin
            check(!plot && !busy && !done, "reset_outputs", {29'd0, plot, busy, done}, 0);
            exp_q.delete();
            active     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            was_active = active;
            if (active) cyc++;
            if (prev_stall) begin
                check(plot && plot_x == prev_pix.x && plot_y == prev_pix.y && plot_colour == prev_pix.c,
                      "stall_hold", {15'd0, plot, plot_x, plot_y}, {15'd1, prev_pix.x, prev_pix.y});
            end
            if (plot && plot_ready) begin
                if (!active || exp_q.size() == 0) begin
                    check(1'b0, "extra_plot", {16'd0, plot_x, plot_y}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(plot_x == e.x && plot_y == e.y && plot_colour == e.c, "plot_pixel",
                          {10'd0, plot_x, plot_y, plot_colour}, {10'd0, e.x, e.y, e.c});
                end
                got_log.push_back('{plot_x, plot_y, plot_colour});
            end
            prev_stall = plot && !plot_ready;
            prev_pix   = '{plot_x, plot_y, plot_colour};
            if (active) begin
                if (done) begin
                    check(exp_q.size() == 0, "done_after_all_plots", exp_q.size(), 0);
                    check(!busy && !plot, "fin_outputs", {30'd0, busy, plot}, 0);
                    done_cyc = cyc;
                    done_cnt++;
                    active = 1'b0;
                end else begin
                    check(busy, "busy_during_op", {31'd0, busy}, 1);
                    if (cyc > 4000) begin
                        check(1'b0, "op_timeout", cyc, 4000);
                        active = 1'b0;
                    end
                end
            end else begin
                check(!done && !plot, "idle_quiet", {30'd0, done, plot}, 0);
            end
            if (!was_active && start) begin
                build_expect(origin_x, origin_y);
                active = 1'b1;
                cyc    = 0;
            end
        end
    end

    // plot_ready driver: constant 1, or the 1,0,0 repeating pattern.
    initial begin
        plot_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                plot_ready = 1'b1;
            end else begin
                plot_ready = (ready_ph == 0);
                ready_ph   = (ready_ph + 1) % 3;
            end
        end
    end

    task automatic start_char(input logic [7:0] ox, input logic [7:0] oy);
        @(posedge clk);
        #1;
        start    = 1'b1;
        origin_x = ox;
        origin_y = oy;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n0 = done_cnt;
        int k  = 0;
        while (done_cnt == n0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(done_cnt != n0, "done_timeout", done_cnt, n0 + 1);
        @(negedge clk);
    endtask

    task automatic chk_pix(input int idx, input logic [7:0] x, input logic [7:0] y, input string name);
        if (idx >= got_log.size()) begin
            check(1'b0, name, got_log.size(), idx + 1);
        end else begin
            check(got_log[idx].x == x && got_log[idx].y == y, name,
                  {16'd0, got_log[idx].x, got_log[idx].y}, {16'd0, x, y});
        end
    endtask

    task automatic chk_count(input string name);
        int fg_n = 0;
        foreach (got_log[i]) if (got_log[i].c == FG) fg_n++;
`ifdef CLEAR_BG_EN
        check(got_log.size() == 80, name, got_log.size(), 80);
`else
        check(got_log.size() == 16, name, got_log.size(), 16);
`endif
        check(fg_n == 16, {name, "_fg"}, fg_n, 16);
    endtask

    initial begin
        int n0;
        resetn   = 1'b0;
        start    = 1'b0;
        origin_x = 8'd0;
        origin_y = 8'd0;
        repeat (3) @(negedge clk);
        check(char_x == 8'd0 && char_y == 8'd0 && plot_x == 8'd0 && plot_y == 8'd0 &&
              plot_colour == 6'd0, "reset_regs", {char_x, char_y, plot_x, plot_y}, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Glyph F at (20,30), ready held high.
        start_char(8'd20, 8'd30);
        wait_done();
        check(done_cyc == 82, "done_latency", done_cyc, 82);
        chk_count("f_count");
`ifdef CLEAR_BG_EN
        chk_pix(0, 8'd20, 8'd30, "clr_first");
        chk_pix(3, 8'd23, 8'd30, "clr_col3_row0");
        chk_pix(79, 8'd27, 8'd39, "clr_last");
`else
        chk_pix(0, 8'd23, 8'd30, "f_first");
        chk_pix(3, 8'd26, 8'd30, "f_row0_end");
        chk_pix(4, 8'd23, 8'd31, "f_col3_row1");
        chk_pix(9, 8'd24, 8'd35, "f_row5");
        chk_pix(11, 8'd26, 8'd35, "f_row5_end");
        chk_pix(15, 8'd23, 8'd39, "f_last");
`endif

        // Same glyph with plot_ready toggling 1,0,0.
        ready_mode = 1;
        start_char(8'd20, 8'd30);
        wait_done();
        chk_count("stall_count");
        check(done_cyc > 82, "stall_done_late", done_cyc, 83);
        ready_mode = 0;

        // Wrapping origin.
        start_char(8'd252, 8'd250);
        wait_done();
        chk_count("wrap_count");
`ifdef CLEAR_BG_EN
        chk_pix(3, 8'd255, 8'd250, "wrap_255");
        chk_pix(4, 8'd0, 8'd250, "wrap_0");
        chk_pix(79, 8'd3, 8'd3, "wrap_last");
`else
        chk_pix(0, 8'd255, 8'd250, "wrap_255");
        chk_pix(1, 8'd0, 8'd250, "wrap_0");
        chk_pix(3, 8'd2, 8'd250, "wrap_2");
        chk_pix(15, 8'd255, 8'd3, "wrap_last");
`endif

        // Start while busy is ignored; a later start uses the new origin.
        start_char(8'd20, 8'd30);
        repeat (10) @(posedge clk);
        start_char(8'd100, 8'd100);
        wait_done();
        chk_count("busy_start_count");
`ifdef CLEAR_BG_EN
        chk_pix(0, 8'd20, 8'd30, "busy_start_orig");
`else
        chk_pix(0, 8'd23, 8'd30, "busy_start_orig");
`endif
        start_char(8'd100, 8'd100);
        wait_done();
`ifdef CLEAR_BG_EN
        chk_pix(0, 8'd100, 8'd100, "second_origin");
`else
        chk_pix(0, 8'd103, 8'd100, "second_origin");
`endif

        // Reset around scan pixel 40, then a clean render.
        n0 = done_cnt;
        start_char(8'd20, 8'd30);
        repeat (39) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check(!plot && !busy && !done, "async_reset", {29'd0, plot, busy, done}, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check(done_cnt == n0, "no_done_after_abort", done_cnt, n0);
        start_char(8'd20, 8'd30);
        wait_done();
        check(done_cnt == n0 + 1, "render_after_reset", done_cnt, n0 + 1);
        check(done_cyc == 82, "latency_after_reset", done_cyc, 82);
        chk_count("reset_count");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
